// File: rtl/tl_pkg.sv
// Shared light encodings, error codes, lane indices and helpers for traffic_light_monitor.
package tl_pkg;

    localparam int unsigned LIGHT_W   = 3;
    localparam int unsigned NUM_LANES = 4;
    localparam int unsigned LANE_W    = 2;
    localparam int unsigned CODE_W    = 3;
    localparam int unsigned NUM_CODES = 6;
    localparam int unsigned COUNT_W   = 8;
    localparam int unsigned PHASE_W   = 16;

    localparam logic [LIGHT_W-1:0] RED    = 3'b100;
    localparam logic [LIGHT_W-1:0] YELLOW = 3'b010;
    localparam logic [LIGHT_W-1:0] GREEN  = 3'b001;

    typedef enum logic [CODE_W-1:0] {
        ERR_ENC       = 3'd0,
        ERR_CONFLICT  = 3'd1,
        ERR_BAD_TRANS = 3'd2,
        ERR_SHORT_YEL = 3'd3,
        ERR_LONG_GRN  = 3'd4
    } err_code_e;

    localparam logic [LANE_W-1:0] LANE_M1 = 2'd0;
    localparam logic [LANE_W-1:0] LANE_M2 = 2'd1;
    localparam logic [LANE_W-1:0] LANE_MT = 2'd2;
    localparam logic [LANE_W-1:0] LANE_S  = 2'd3;

    function automatic logic light_valid(input logic [LIGHT_W-1:0] l);
        return (l == RED) || (l == YELLOW) || (l == GREEN);
    endfunction

    // Only the forward cycle R -> G -> Y -> R is allowed.
    function automatic logic legal_step(input logic [LIGHT_W-1:0] from,
                                        input logic [LIGHT_W-1:0] to);
        return ((from == RED)    && (to == GREEN))  ||
               ((from == GREEN)  && (to == YELLOW)) ||
               ((from == YELLOW) && (to == RED));
    endfunction

    function automatic logic [LANE_W-1:0] lowest_lane(input logic [NUM_LANES-1:0] v);
        lowest_lane = '0;
        for (int i = NUM_LANES - 1; i >= 0; i--) begin
            if (v[i]) lowest_lane = LANE_W'(i);
        end
    endfunction

endpackage

// File: rtl/tl_lane_tracker.sv
// Per-lane history: previous light, armed bit and saturating dwell counter,
// with combinational decode of the current sample against that history.
module tl_lane_tracker
    import tl_pkg::*;
#(
    parameter int unsigned YELLOW_MIN = 3,
    parameter int unsigned GREEN_MAX  = 10,
    parameter int unsigned CNT_W      = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sample_valid,
    input  logic [LIGHT_W-1:0] light,
    output logic               is_green,
    output logic               is_red,
    output logic               enc_err,
    output logic               trans_err,
    output logic               short_yel,
    output logic               long_grn,
    output logic               red_to_green
);

    logic [LIGHT_W-1:0] prev;
    logic               armed;
    logic [CNT_W-1:0]   dwell;
    logic [CNT_W-1:0]   dwell_next;
    logic               enc_ok;
    logic               check;
    logic               changed;

    // Checks only apply to a valid sample on a lane with known history.
    always_comb begin
        enc_ok     = light_valid(light);
        check      = sample_valid && enc_ok && armed;
        changed    = (light != prev);
        dwell_next = dwell;
        if (!armed || changed) begin
            dwell_next = CNT_W'(1);
        end else if (dwell != '1) begin
            dwell_next = dwell + CNT_W'(1);
        end
        is_green     = sample_valid && (light == GREEN);
        is_red       = sample_valid && (light == RED);
        enc_err      = sample_valid && !enc_ok;
        trans_err    = check && changed && !legal_step(prev, light);
        short_yel    = check && (prev == YELLOW) && (light == RED) &&
                       (dwell < CNT_W'(YELLOW_MIN));
        long_grn     = check && (light == GREEN) && (dwell_next == CNT_W'(GREEN_MAX));
        red_to_green = check && (prev == RED) && (light == GREEN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev  <= RED;
            armed <= 1'b0;
            dwell <= '0;
        end else if (sample_valid) begin
            if (enc_ok) begin
                prev  <= light;
                armed <= 1'b1;
                dwell <= dwell_next;
            end else begin
                armed <= 1'b0;
                dwell <= '0;
            end
        end
    end

endmodule

// File: rtl/traffic_light_monitor.sv
// Passive checker on the traffic light buses: registers the lights, tracks each lane and
// reports prioritised error events, sticky flags and counters. TLM_STATS_EN enables phase_count.
module traffic_light_monitor
    import tl_pkg::*;
#(
    parameter int unsigned YELLOW_MIN = 3,
    parameter int unsigned GREEN_MAX  = 10,
    parameter int unsigned CNT_W      = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [LIGHT_W-1:0]   light_M1,
    input  logic [LIGHT_W-1:0]   light_M2,
    input  logic [LIGHT_W-1:0]   light_MT,
    input  logic [LIGHT_W-1:0]   light_S,
    input  logic                 clr,
    output logic                 err_valid,
    output logic [CODE_W-1:0]    err_code,
    output logic [LANE_W-1:0]    err_lane,
    output logic [NUM_CODES-1:0] err_flags,
    output logic [COUNT_W-1:0]   err_count,
    output logic [PHASE_W-1:0]   phase_count
);

    logic [LIGHT_W-1:0]   sample [NUM_LANES];
    logic                 sample_valid;
    logic [NUM_LANES-1:0] is_green;
    logic [NUM_LANES-1:0] is_red;
    logic [NUM_LANES-1:0] enc_err;
    logic [NUM_LANES-1:0] trans_err;
    logic [NUM_LANES-1:0] short_yel;
    logic [NUM_LANES-1:0] long_grn;
    logic [NUM_LANES-1:0] red_to_green;
    logic                 conflict_s;
    logic                 conflict_mt;
    logic [NUM_CODES-1:0] raised;
    logic                 any_err;
    err_code_e            sel_code;
    logic [LANE_W-1:0]    sel_lane;

    // sample_valid keeps the stale post-reset sample register out of the checks.
    always_ff @(posedge clk) begin
        if (rst) begin
            sample_valid    <= 1'b0;
            sample[LANE_M1] <= RED;
            sample[LANE_M2] <= RED;
            sample[LANE_MT] <= RED;
            sample[LANE_S]  <= RED;
        end else begin
            sample_valid    <= 1'b1;
            sample[LANE_M1] <= light_M1;
            sample[LANE_M2] <= light_M2;
            sample[LANE_MT] <= light_MT;
            sample[LANE_S]  <= light_S;
        end
    end

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        tl_lane_tracker #(
            .YELLOW_MIN (YELLOW_MIN),
            .GREEN_MAX  (GREEN_MAX),
            .CNT_W      (CNT_W)
        ) u_lane (
            .clk          (clk),
            .rst          (rst),
            .sample_valid (sample_valid),
            .light        (sample[i]),
            .is_green     (is_green[i]),
            .is_red       (is_red[i]),
            .enc_err      (enc_err[i]),
            .trans_err    (trans_err[i]),
            .short_yel    (short_yel[i]),
            .long_grn     (long_grn[i]),
            .red_to_green (red_to_green[i])
        );
    end

    // Conflict detection and single-event priority selection.
    always_comb begin
        conflict_s  = is_green[LANE_S] &&
                      !(is_red[LANE_M1] && is_red[LANE_M2] && is_red[LANE_MT]);
        conflict_mt = is_green[LANE_MT] && is_green[LANE_M2];
        raised      = {1'b0, |long_grn, |short_yel, |trans_err,
                       conflict_s | conflict_mt, |enc_err};
        any_err     = |raised;
        sel_code    = ERR_ENC;
        sel_lane    = LANE_M1;
        if (conflict_mt) begin
            sel_code = ERR_CONFLICT;
            sel_lane = LANE_MT;
        end else if (conflict_s) begin
            sel_code = ERR_CONFLICT;
            sel_lane = LANE_S;
        end else if (|enc_err) begin
            sel_code = ERR_ENC;
            sel_lane = lowest_lane(enc_err);
        end else if (|trans_err) begin
            sel_code = ERR_BAD_TRANS;
            sel_lane = lowest_lane(trans_err);
        end else if (|short_yel) begin
            sel_code = ERR_SHORT_YEL;
            sel_lane = lowest_lane(short_yel);
        end else if (|long_grn) begin
            sel_code = ERR_LONG_GRN;
            sel_lane = lowest_lane(long_grn);
        end
    end

    // A same-cycle error takes precedence over clr.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_valid <= 1'b0;
            err_code  <= '0;
            err_lane  <= '0;
            err_flags <= '0;
            err_count <= '0;
        end else begin
            err_valid <= any_err;
            if (any_err) begin
                err_code <= sel_code;
                err_lane <= sel_lane;
            end
            err_flags <= clr ? raised : (err_flags | raised);
            if (clr) begin
                err_count <= any_err ? COUNT_W'(1) : '0;
            end else if (any_err && (err_count != '1)) begin
                err_count <= err_count + COUNT_W'(1);
            end
        end
    end

    logic unused_lane_bits;
    assign unused_lane_bits = is_green[LANE_M1] ^ is_red[LANE_S];

`ifdef TLM_STATS_EN
    logic [PHASE_W-1:0] phase_inc;

    always_comb begin
        phase_inc = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            phase_inc = phase_inc + PHASE_W'(red_to_green[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_count <= '0;
        end else begin
            phase_count <= phase_count + phase_inc;
        end
    end
`else
    logic unused_red_to_green;
    assign unused_red_to_green = ^red_to_green;
    assign phase_count         = '0;
`endif

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Randomised and directed bench for traffic_light_monitor against a rule-level reference model.
module tb_traffic_light_monitor;

    localparam int unsigned YMIN = 3;
    localparam int unsigned GMAX = 10;
    localparam int unsigned CW   = 8;
    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] G = 3'b001;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  light_M1 = R;
    logic [2:0]  light_M2 = R;
    logic [2:0]  light_MT = R;
    logic [2:0]  light_S  = R;
    logic        clr = 1'b0;
    logic        err_valid;
    logic [2:0]  err_code;
    logic [1:0]  err_lane;
    logic [5:0]  err_flags;
    logic [7:0]  err_count;
    logic [15:0] phase_count;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state: colour 0 = red, 1 = yellow, 2 = green.
    bit          m_known [4];
    int          m_col   [4];
    int          m_dwell [4];
    logic [2:0]  pend    [4];
    bit          pend_vld;
    bit          exp_valid;
    logic [2:0]  exp_code;
    logic [1:0]  exp_lane;
    logic [5:0]  exp_flags;
    logic [7:0]  exp_count;
    logic [15:0] exp_phase;

    always #5 clk = ~clk;

    traffic_light_monitor #(
        .YELLOW_MIN (YMIN),
        .GREEN_MAX  (GMAX),
        .CNT_W      (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .light_M1    (light_M1),
        .light_M2    (light_M2),
        .light_MT    (light_MT),
        .light_S     (light_S),
        .clr         (clr),
        .err_valid   (err_valid),
        .err_code    (err_code),
        .err_lane    (err_lane),
        .err_flags   (err_flags),
        .err_count   (err_count),
        .phase_count (phase_count)
    );

    function automatic int decode(input logic [2:0] l);
        case (l)
            R:       return 0;
            Y:       return 1;
            G:       return 2;
            default: return -1;
        endcase
    endfunction

    function automatic logic [2:0] next_light(input logic [2:0] l);
        case (l)
            R:       return G;
            G:       return Y;
            Y:       return R;
            default: return R;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_known[i] = 1'b0;
            m_col[i]   = 0;
            m_dwell[i] = 0;
            pend[i]    = R;
        end
        pend_vld  = 1'b0;
        exp_valid = 1'b0;
        exp_code  = '0;
        exp_lane  = '0;
        exp_flags = '0;
        exp_count = '0;
        exp_phase = '0;
    endtask

    // Apply the rules to the pending sample; clr_i is the clr seen at the reporting edge.
    task automatic model_eval(input bit clr_i);
        int         col [4];
        bit         enc_l [4];
        bit         tr_l  [4];
        bit         sh_l  [4];
        bit         lg_l  [4];
        int         succ  [3];
        int         rg;
        int         nd;
        int         code;
        int         lane;
        bit         cf_s;
        bit         cf_mt;
        bit         found;
        bit         hit;
        logic [5:0] raised;
        succ   = '{2, 0, 1};
        raised = '0;
        rg     = 0;
        code   = 0;
        lane   = 0;
        if (pend_vld) begin
            for (int i = 0; i < 4; i++) begin
                col[i]   = decode(pend[i]);
                enc_l[i] = (col[i] < 0);
                tr_l[i]  = 1'b0;
                sh_l[i]  = 1'b0;
                lg_l[i]  = 1'b0;
            end
            cf_s  = (col[3] == 2) && ((pend[0] !== R) || (pend[1] !== R) || (pend[2] !== R));
            cf_mt = (col[2] == 2) && (col[1] == 2);
            for (int i = 0; i < 4; i++) begin
                if (col[i] < 0) begin
                    m_known[i] = 1'b0;
                end else if (!m_known[i]) begin
                    m_known[i] = 1'b1;
                    m_col[i]   = col[i];
                    m_dwell[i] = 1;
                end else begin
                    if (col[i] == m_col[i]) nd = (m_dwell[i] < 255) ? m_dwell[i] + 1 : 255;
                    else nd = 1;
                    if (col[i] != m_col[i]) begin
                        tr_l[i] = (col[i] != succ[m_col[i]]);
                        sh_l[i] = (m_col[i] == 1) && (col[i] == 0) && (m_dwell[i] < int'(YMIN));
                        if ((m_col[i] == 0) && (col[i] == 2)) rg++;
                    end
                    lg_l[i]    = (col[i] == 2) && (nd == int'(GMAX));
                    m_col[i]   = col[i];
                    m_dwell[i] = nd;
                end
            end
            for (int i = 0; i < 4; i++) begin
                raised[0] = raised[0] | enc_l[i];
                raised[2] = raised[2] | tr_l[i];
                raised[3] = raised[3] | sh_l[i];
                raised[4] = raised[4] | lg_l[i];
            end
            raised[1] = cf_s | cf_mt;
            if (cf_mt) begin
                code = 1; lane = 2;
            end else if (cf_s) begin
                code = 1; lane = 3;
            end else begin
                found = 1'b0;
                for (int p = 0; p < 4; p++) begin
                    for (int i = 0; i < 4; i++) begin
                        hit = (p == 0) ? enc_l[i] : (p == 1) ? tr_l[i] : (p == 2) ? sh_l[i] : lg_l[i];
                        if (hit && !found) begin
                            found = 1'b1;
                            code  = (p == 0) ? 0 : p + 1;
                            lane  = i;
                        end
                    end
                end
            end
        end
        exp_valid = (raised != 6'd0);
        if (exp_valid) begin
            exp_code = 3'(code);
            exp_lane = 2'(lane);
        end
        exp_flags = clr_i ? raised : (exp_flags | raised);
        if (clr_i) exp_count = exp_valid ? 8'd1 : 8'd0;
        else if (exp_valid && (exp_count != 8'hFF)) exp_count = exp_count + 8'd1;
`ifdef TLM_STATS_EN
        exp_phase = exp_phase + 16'(rg);
`else
        exp_phase = 16'd0;
`endif
    endtask

    // Drive one cycle of inputs, advance the model to the next edge, sample 1 ns after it.
    task automatic tick(input logic [2:0] a, input logic [2:0] b, input logic [2:0] c,
                        input logic [2:0] d, input bit clr_i, input bit rst_i);
        light_M1 = a;
        light_M2 = b;
        light_MT = c;
        light_S  = d;
        clr      = clr_i;
        rst      = rst_i;
        if (rst_i) begin
            model_reset();
        end else begin
            model_eval(clr_i);
            pend[0]  = a;
            pend[1]  = b;
            pend[2]  = c;
            pend[3]  = d;
            pend_vld = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        tick(3'($urandom_range(7)), 3'($urandom_range(7)), 3'($urandom_range(7)), 3'($urandom_range(7)), 1'b0, 1'b1);
        tick(3'($urandom_range(7)), 3'($urandom_range(7)), 3'($urandom_range(7)), 3'($urandom_range(7)), 1'b1, 1'b1);
        n_checks++; if (err_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", err_valid); else n_pass++;
        n_checks++; if (err_code !== 3'd0) $display("FAIL reset_code: got %0d want 0", err_code); else n_pass++;
        n_checks++; if (err_lane !== 2'd0) $display("FAIL reset_lane: got %0d want 0", err_lane); else n_pass++;
        n_checks++; if (err_flags !== 6'd0) $display("FAIL reset_flags: got %b want 000000", err_flags); else n_pass++;
        n_checks++; if (err_count !== 8'd0) $display("FAIL reset_count: got %0d want 0", err_count); else n_pass++;
        n_checks++; if (phase_count !== 16'd0) $display("FAIL reset_phase: got %0d want 0", phase_count); else n_pass++;
    endtask

    task automatic test_legal_cycle();
        logic [2:0]  seq [$];
        int          pulses;
        logic [15:0] want_phase;
        logic [15:0] p0;
        pulses = 0;
        p0     = exp_phase;
        for (int k = 0; k < 5; k++) seq.push_back(R);
        for (int k = 0; k < 5; k++) seq.push_back(G);
        for (int k = 0; k < 3; k++) seq.push_back(Y);
        for (int k = 0; k < 3; k++) seq.push_back(R);
        tick(R, R, R, R, 1'b0, 1'b0);
        foreach (seq[k]) begin
            tick(seq[k], R, R, R, 1'b0, 1'b0);
            if (err_valid === 1'b1) pulses++;
            n_checks++;
            if (err_valid !== exp_valid) $display("FAIL legal_valid tick %0d: got %b want %b", k, err_valid, exp_valid);
            else n_pass++;
        end
`ifdef TLM_STATS_EN
        want_phase = p0 + 16'd1;
`else
        want_phase = 16'd0;
`endif
        n_checks++; if (pulses !== 0) $display("FAIL legal_pulses: got %0d want 0", pulses); else n_pass++;
        n_checks++; if (phase_count !== want_phase) $display("FAIL legal_phase: got %0d want %0d", phase_count, want_phase); else n_pass++;
    endtask

    task automatic test_bad_trans();
        logic [2:0] seq [$];
        int         pulses;
        logic [2:0] got_code;
        logic [1:0] got_lane;
        pulses = 0; got_code = '1; got_lane = '1;
        seq = '{G, G, R, R, R};
        tick(R, R, R, R, 1'b1, 1'b0);
        foreach (seq[k]) begin
            tick(seq[k], R, R, R, 1'b0, 1'b0);
            if (err_valid === 1'b1) begin pulses++; got_code = err_code; got_lane = err_lane; end
            n_checks++;
            if (err_valid !== exp_valid) $display("FAIL bad_trans_valid tick %0d: got %b want %b", k, err_valid, exp_valid);
            else n_pass++;
        end
        n_checks++; if (pulses !== 1) $display("FAIL bad_trans_pulses: got %0d want 1", pulses); else n_pass++;
        n_checks++; if (got_code !== 3'd2) $display("FAIL bad_trans_code: got %0d want 2", got_code); else n_pass++;
        n_checks++; if (got_lane !== 2'd0) $display("FAIL bad_trans_lane: got %0d want 0", got_lane); else n_pass++;
        n_checks++; if (err_flags !== 6'b000100) $display("FAIL bad_trans_flags: got %b want 000100", err_flags); else n_pass++;
    endtask

    task automatic test_short_yellow();
        logic [2:0] seq [$];
        int         pulses;
        logic [2:0] got_code;
        logic [1:0] got_lane;
        pulses = 0; got_code = '1; got_lane = '1;
        seq = '{G, G, Y, Y, R, R, R};
        tick(R, R, R, R, 1'b1, 1'b0);
        foreach (seq[k]) begin
            tick(R, seq[k], R, R, 1'b0, 1'b0);
            if (err_valid === 1'b1) begin pulses++; got_code = err_code; got_lane = err_lane; end
            n_checks++;
            if (err_valid !== exp_valid) $display("FAIL short_yel_valid tick %0d: got %b want %b", k, err_valid, exp_valid);
            else n_pass++;
        end
        n_checks++; if (pulses !== 1) $display("FAIL short_yel_pulses: got %0d want 1", pulses); else n_pass++;
        n_checks++; if (got_code !== 3'd3) $display("FAIL short_yel_code: got %0d want 3", got_code); else n_pass++;
        n_checks++; if (got_lane !== 2'd1) $display("FAIL short_yel_lane: got %0d want 1", got_lane); else n_pass++;
        n_checks++; if (err_flags !== 6'b001000) $display("FAIL short_yel_flags: got %b want 001000", err_flags); else n_pass++;
    endtask

    task automatic test_conflict();
        logic [2:0] s_m1 [$];
        logic [2:0] s_mt [$];
        logic [2:0] s_s  [$];
        int         pulses;
        logic [2:0] got_code;
        logic [1:0] got_lane;
        pulses = 0; got_code = '1; got_lane = '1;
        s_m1 = '{G, Y,      Y, Y, R, R, R, R};
        s_mt = '{R, 3'b011, R, R, R, R, R, R};
        s_s  = '{R, G,      Y, Y, Y, R, R, R};
        tick(R, R, R, R, 1'b1, 1'b0);
        foreach (s_m1[k]) begin
            tick(s_m1[k], R, s_mt[k], s_s[k], 1'b0, 1'b0);
            if (err_valid === 1'b1) begin pulses++; got_code = err_code; got_lane = err_lane; end
            n_checks++;
            if (err_valid !== exp_valid) $display("FAIL conflict_valid tick %0d: got %b want %b", k, err_valid, exp_valid);
            else n_pass++;
        end
        n_checks++; if (pulses !== 1) $display("FAIL conflict_pulses: got %0d want 1", pulses); else n_pass++;
        n_checks++; if (got_code !== 3'd1) $display("FAIL conflict_code: got %0d want 1", got_code); else n_pass++;
        n_checks++; if (got_lane !== 2'd3) $display("FAIL conflict_lane: got %0d want 3", got_lane); else n_pass++;
        n_checks++; if (err_flags !== 6'b000011) $display("FAIL conflict_flags: got %b want 000011", err_flags); else n_pass++;
        n_checks++; if (err_count !== 8'd1) $display("FAIL conflict_count: got %0d want 1", err_count); else n_pass++;
    endtask

    task automatic test_long_green();
        logic [2:0] seq [$];
        int         pulses;
        int         pulse_at;
        logic [2:0] got_code;
        logic [1:0] got_lane;
        pulses = 0; pulse_at = -1; got_code = '1; got_lane = '1;
        for (int k = 0; k < 12; k++) seq.push_back(G);
        for (int k = 0; k < 3; k++) seq.push_back(Y);
        for (int k = 0; k < 3; k++) seq.push_back(R);
        tick(R, R, R, R, 1'b1, 1'b0);
        foreach (seq[k]) begin
            tick(R, R, seq[k], R, 1'b0, 1'b0);
            if (err_valid === 1'b1) begin pulses++; pulse_at = k; got_code = err_code; got_lane = err_lane; end
            n_checks++;
            if (err_valid !== exp_valid) $display("FAIL long_grn_valid tick %0d: got %b want %b", k, err_valid, exp_valid);
            else n_pass++;
        end
        n_checks++; if (pulses !== 1) $display("FAIL long_grn_pulses: got %0d want 1", pulses); else n_pass++;
        n_checks++; if (pulse_at !== 10) $display("FAIL long_grn_timing: got tick %0d want tick 10", pulse_at); else n_pass++;
        n_checks++; if (got_code !== 3'd4) $display("FAIL long_grn_code: got %0d want 4", got_code); else n_pass++;
        n_checks++; if (got_lane !== 2'd2) $display("FAIL long_grn_lane: got %0d want 2", got_lane); else n_pass++;
    endtask

    task automatic test_clr_rst();
        int pulses;
        pulses = 0;
        tick(Y, R, R, R, 1'b0, 1'b0);
        tick(R, R, R, R, 1'b0, 1'b0);
        tick(R, R, R, R, 1'b0, 1'b0);
        n_checks++; if (err_flags !== exp_flags) $display("FAIL clr_pre_flags: got %b want %b", err_flags, exp_flags); else n_pass++;
        tick(R, R, R, R, 1'b1, 1'b0);
        n_checks++; if (err_flags !== 6'd0) $display("FAIL clr_flags: got %b want 000000", err_flags); else n_pass++;
        n_checks++; if (err_count !== 8'd0) $display("FAIL clr_count: got %0d want 0", err_count); else n_pass++;
        tick(G, R, R, R, 1'b0, 1'b0);
        tick(Y, R, R, R, 1'b0, 1'b0);
        tick(Y, R, R, R, 1'b0, 1'b1);
        n_checks++; if (err_flags !== 6'd0) $display("FAIL rst_flags: got %b want 000000", err_flags); else n_pass++;
        n_checks++; if (err_count !== 8'd0) $display("FAIL rst_count: got %0d want 0", err_count); else n_pass++;
        for (int k = 0; k < 4; k++) begin
            tick(R, R, R, R, 1'b0, 1'b0);
            if (err_valid === 1'b1) pulses++;
        end
        n_checks++; if (pulses !== 0) $display("FAIL rst_first_sample: got %0d pulses want 0", pulses); else n_pass++;
    endtask

    task automatic test_count_saturation();
        tick(R, R, R, R, 1'b1, 1'b0);
        for (int k = 0; k < 262; k++) tick(G, R, R, G, 1'b0, 1'b0);
        n_checks++; if (err_count !== 8'hFF) $display("FAIL count_saturate: got %0d want 255", err_count); else n_pass++;
        n_checks++; if (err_flags !== exp_flags) $display("FAIL count_sat_flags: got %b want %b", err_flags, exp_flags); else n_pass++;
    endtask

    task automatic test_random();
        logic [2:0] cur [4];
        int         r;
        bit         clr_i;
        bit         rst_i;
        for (int i = 0; i < 4; i++) cur[i] = R;
        for (int t = 0; t < 600; t++) begin
            for (int i = 0; i < 4; i++) begin
                r = int'($urandom_range(99));
                if (r < 82) begin
                    cur[i] = cur[i];
                end else if (r < 94) begin
                    cur[i] = next_light(cur[i]);
                end else if (r < 97) begin
                    case ($urandom_range(2))
                        0:       cur[i] = R;
                        1:       cur[i] = Y;
                        default: cur[i] = G;
                    endcase
                end else begin
                    cur[i] = 3'($urandom_range(7));
                end
            end
            clr_i = ($urandom_range(99) < 3);
            rst_i = ($urandom_range(199) < 1);
            tick(cur[0], cur[1], cur[2], cur[3], clr_i, rst_i);
            n_checks++;
            if (err_valid !== exp_valid) $display("FAIL rand_valid t=%0d: got %b want %b", t, err_valid, exp_valid);
            else n_pass++;
            if (exp_valid) begin
                n_checks++;
                if (err_code !== exp_code) $display("FAIL rand_code t=%0d: got %0d want %0d", t, err_code, exp_code);
                else n_pass++;
                n_checks++;
                if (err_lane !== exp_lane) $display("FAIL rand_lane t=%0d: got %0d want %0d", t, err_lane, exp_lane);
                else n_pass++;
            end
            n_checks++;
            if (err_flags !== exp_flags) $display("FAIL rand_flags t=%0d: got %b want %b", t, err_flags, exp_flags);
            else n_pass++;
            n_checks++;
            if (err_count !== exp_count) $display("FAIL rand_count t=%0d: got %0d want %0d", t, err_count, exp_count);
            else n_pass++;
            n_checks++;
            if (phase_count !== exp_phase) $display("FAIL rand_phase t=%0d: got %0d want %0d", t, phase_count, exp_phase);
            else n_pass++;
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_legal_cycle();
        test_bad_trans();
        test_short_yellow();
        test_conflict();
        test_long_green();
        test_clr_rst();
        test_count_saturation();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
